clk_div_monitor: RTL and testbench
==================================

# clk_div_monitor

Receive-side companion to the team's even-ratio 50%-duty clock dividers. Samples a divided clock in the fast `i_clk` domain, measures high-phase, low-phase and period lengths in `i_clk` cycles, and checks them against the expected ratio. Declares lock after a run of good periods and flags any deviation. Sits beside each divider output as a built-in self-check and health monitor.

## Interface
Parameters:
- `DIV`, 8, expected divide ratio; even, ≥ 4.
- `CNT_W`, 8, width of the phase counters; must satisfy 2^CNT_W − 1 > DIV.
- `LOCK_CNT`, 4, number of consecutive good periods required to assert lock.
- `TOL`, 0, allowed ± deviation of each phase from DIV/2, in cycles.

Ports (one clock; reset is synchronous and active-low):
- `i_clk`  in  1  fast reference clock.
- `i_rst_n`  in  1  synchronous active-low reset.
- `i_en`  in  1  monitor enable.
- `i_div_clk`  in  1  divided clock under test; treated as asynchronous.
- `o_rise`  out  1  one-cycle pulse per detected rising edge.
- `o_fall`  out  1  one-cycle pulse per detected falling edge.
- `o_high_len`  out  CNT_W  last measured high-phase length.
- `o_low_len`  out  CNT_W  last measured low-phase length.
- `o_period`  out  CNT_W+1  last measured period (high + low).
- `o_meas_vld`  out  1  one-cycle pulse when `o_period` is updated.
- `o_locked`  out  1  level; asserted after LOCK_CNT consecutive good periods.
- `o_err`  out  1  one-cycle pulse on a bad period or a timeout.

## Operation
**Input path**
- `i_div_clk` passes through a 2-flop synchronizer.
- A delay flop on the synchronized value feeds edge detection.
- `o_rise` and `o_fall` are registered.

**State machine**
- IDLE: entered on reset or whenever `i_en`=0. Moves to WAIT_RISE when `i_en`=1.
- WAIT_RISE: discards the partial period. On rise, moves to HIGH and loads cnt=1.
- HIGH: cnt increments every cycle. On fall, captures `o_high_len`=cnt, loads cnt=1, moves to LOW.
- LOW: cnt increments every cycle. On rise:
  - captures low_len=cnt and `o_period`=high+low;
  - pulses `o_meas_vld`;
  - runs the check;
  - loads cnt=1 and moves to HIGH.

**Period check**
- Good: both phases lie within [DIV/2−TOL, DIV/2+TOL].
- Good period: good_cnt increments, saturating at LOCK_CNT. `o_locked` is set when good_cnt reaches LOCK_CNT.
- Bad period: `o_err` pulses, good_cnt is cleared, `o_locked` is cleared, and the state stays HIGH (the new period is already in progress).

**Timeout**
- If cnt reaches 2^CNT_W−1 in HIGH or LOW (stuck clock): `o_err` pulses once, good_cnt and `o_locked` are cleared, and the state goes to WAIT_RISE.
- cnt saturates and never wraps.

**Disable**
- `i_en`=0: state goes to IDLE, `o_locked` clears, no pulses are produced.
- Length outputs hold their last values.

**Reset values**
- Every output is 0; good_cnt is 0; synchronizer flops are 0.

## Timing
- i_div_clk first sampled high at posedge k:
  - `o_rise` is high in cycle k+3, i.e. after the posedge at k+2.
  - Falls follow identically.
- Length latency:
  - `o_high_len` updates in the same cycle as its `o_fall` pulse.
  - `o_low_len`, `o_period` and `o_meas_vld` update in the same cycle as the closing `o_rise`.
  - `o_err`/`o_locked` change in that cycle too.
- Ideal synchronous DIV=8 input: high=4, low=4, period=8.
- `o_locked` rises LOCK_CNT full periods after the first measured rise.
- Reset mid-period: all outputs drop to 0 on the next posedge. Measurement restarts from WAIT_RISE. A rise in the first cycle after reset release is not captured until the synchronizer refills.
- Simultaneous timeout and edge in the same cycle: the edge wins and the normal capture proceeds.

## Structure
- Package `clk_div_mon_pkg` holds:
  - `state_t` enum (IDLE, WAIT_RISE, HIGH, LOW);
  - the default constants DIV/CNT_W/LOCK_CNT.
- Sub-module `sync_2ff`: a 1-bit two-flop synchronizer with synchronous active-low reset, reusable across the codebase.
- Top level contains the edge detect, FSM, counter, check and lock logic.

## Test plan
- Ideal div-by-8 driven from `i_clk` (4 high / 4 low):
  - every `o_meas_vld` shows high=4, low=4, period=8;
  - `o_locked`=1 after 4 periods;
  - `o_err` never fires.
- Locked, then one period with high=5 (TOL=0): `o_err` pulses once and `o_locked` drops. Relock happens 4 good periods later.
- Same run with TOL=1 and high=5: no error, lock is retained.
- Hold `i_div_clk` high after lock (CNT_W=4): `o_err` pulses once at cnt=15, `o_locked`=0, and the state returns to WAIT_RISE. Resumed 4/4 input relocks.
- Assert `i_rst_n`=0 mid-HIGH: all outputs are 0 on the next edge. After release, the first `o_meas_vld` reports 4/4/8.
- Toggle `i_en` low for 10 cycles: no pulses, `o_locked`=0, length outputs hold. Re-enable; lock returns after 4 periods.

Source files
------------

// File: rtl/clk_div_mon_pkg.sv
// Shared types and default constants for the divided-clock monitor.
package clk_div_mon_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWaitRise,
      StHigh,
      StLow
   } state_t;

   localparam int unsigned DefDiv     = 8;
   localparam int unsigned DefCntW    = 8;
   localparam int unsigned DefLockCnt = 4;
   localparam int unsigned DefTol     = 0;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-low reset.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low/period of an asynchronous divided clock in i_clk cycles, checks each
// phase against DIV/2 +/- TOL, and tracks lock over LOCK_CNT consecutive good periods.
module clk_div_monitor
   import clk_div_mon_pkg::*;
#(
   parameter int unsigned DIV      = DefDiv,
   parameter int unsigned CNT_W    = DefCntW,
   parameter int unsigned LOCK_CNT = DefLockCnt,
   parameter int unsigned TOL      = DefTol
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_div_clk,
   output logic             o_rise,
   output logic             o_fall,
   output logic [CNT_W-1:0] o_high_len,
   output logic [CNT_W-1:0] o_low_len,
   output logic [CNT_W:0]   o_period,
   output logic             o_meas_vld,
   output logic             o_locked,
   output logic             o_err
);

   localparam int unsigned      GoodW   = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic [CNT_W-1:0] PhMin   = CNT_W'(DIV / 2 - TOL);
   localparam logic [CNT_W-1:0] PhMax   = CNT_W'(DIV / 2 + TOL);
   localparam logic [GoodW-1:0] GoodSat = GoodW'(LOCK_CNT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, high_q, high_d, low_q, low_d;
   logic [CNT_W:0]   period_q, period_d;
   logic [GoodW-1:0] good_q, good_d;
   logic             div_sync, div_dly_q, edge_rise, edge_fall, timeout;
   logic             rise_q, rise_d, fall_q, fall_d, vld_q, vld_d;
   logic             err_q, err_d, locked_q, locked_d;

   function automatic logic phase_ok(input logic [CNT_W-1:0] len);
      return (len >= PhMin) && (len <= PhMax);
   endfunction

   sync_2ff u_sync (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .d_i    (i_div_clk),
      .q_o    (div_sync)
   );

   assign edge_rise = div_sync & ~div_dly_q;
   assign edge_fall = ~div_sync & div_dly_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      high_d   = high_q;
      low_d    = low_q;
      period_d = period_q;
      good_d   = good_q;
      locked_d = locked_q;
      rise_d   = i_en & edge_rise;
      fall_d   = i_en & edge_fall;
      vld_d    = 1'b0;
      err_d    = 1'b0;
      timeout  = 1'b0;
      if (!i_en) begin
         state_d  = StIdle;
         good_d   = '0;
         locked_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: state_d = StWaitRise;
            StWaitRise: begin
               if (edge_rise) begin
                  state_d = StHigh;
                  cnt_d   = CntOne;
               end
            end
            StHigh: begin
               if (edge_fall) begin
                  high_d  = cnt_q;
                  cnt_d   = CntOne;
                  state_d = StLow;
               end else if (cnt_q == CntMax) begin
                  timeout = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StLow: begin
               // An edge in the saturating cycle still closes the period normally.
               if (edge_rise) begin
                  low_d    = cnt_q;
                  period_d = {1'b0, high_q} + {1'b0, cnt_q};
                  vld_d    = 1'b1;
                  cnt_d    = CntOne;
                  state_d  = StHigh;
                  if (phase_ok(high_q) && phase_ok(cnt_q)) begin
                     good_d   = (good_q == GoodSat) ? good_q : good_q + 1'b1;
                     locked_d = (good_d == GoodSat);
                  end else begin
                     err_d    = 1'b1;
                     good_d   = '0;
                     locked_d = 1'b0;
                  end
               end else if (cnt_q == CntMax) begin
                  timeout = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
         if (timeout) begin
            err_d    = 1'b1;
            good_d   = '0;
            locked_d = 1'b0;
            state_d  = StWaitRise;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         div_dly_q <= 1'b0;
         state_q   <= StIdle;
         cnt_q     <= '0;
         high_q    <= '0;
         low_q     <= '0;
         period_q  <= '0;
         good_q    <= '0;
         locked_q  <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         div_dly_q <= div_sync;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         high_q    <= high_d;
         low_q     <= low_d;
         period_q  <= period_d;
         good_q    <= good_d;
         locked_q  <= locked_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
      end
   end

   assign o_rise     = rise_q;
   assign o_fall     = fall_q;
   assign o_high_len = high_q;
   assign o_low_len  = low_q;
   assign o_period   = period_q;
   assign o_meas_vld = vld_q;
   assign o_locked   = locked_q;
   assign o_err      = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Three monitors (TOL=0, TOL=1, CNT_W=4) share one directed div-clock stream and are
// checked each cycle against an interval-based model plus hand-computed literals.
module tb_clk_div_monitor;

   localparam int NDut = 3;
   localparam int MaxLen [NDut] = '{255, 255, 15};
   localparam int TolV   [NDut] = '{0, 1, 0};
   localparam int LockN  = 4;
   localparam int Half   = 4;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic en      = 1'b0;
   logic div_clk = 1'b0;

   always #5 clk = ~clk;

   logic       rise0, fall0, vld0, lock0, err0;
   logic       rise1, fall1, vld1, lock1, err1;
   logic       rise2, fall2, vld2, lock2, err2;
   logic [7:0] hl0, ll0, hl1, ll1;
   logic [8:0] per0, per1;
   logic [3:0] hl2, ll2;
   logic [4:0] per2;

   clk_div_monitor #(.DIV(8), .CNT_W(8), .LOCK_CNT(4), .TOL(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div_clk(div_clk),
      .o_rise(rise0), .o_fall(fall0), .o_high_len(hl0), .o_low_len(ll0),
      .o_period(per0), .o_meas_vld(vld0), .o_locked(lock0), .o_err(err0)
   );

   clk_div_monitor #(.DIV(8), .CNT_W(8), .LOCK_CNT(4), .TOL(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div_clk(div_clk),
      .o_rise(rise1), .o_fall(fall1), .o_high_len(hl1), .o_low_len(ll1),
      .o_period(per1), .o_meas_vld(vld1), .o_locked(lock1), .o_err(err1)
   );

   clk_div_monitor #(.DIV(8), .CNT_W(4), .LOCK_CNT(4), .TOL(0)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div_clk(div_clk),
      .o_rise(rise2), .o_fall(fall2), .o_high_len(hl2), .o_low_len(ll2),
      .o_period(per2), .o_meas_vld(vld2), .o_locked(lock2), .o_err(err2)
   );

   logic       a_rise [NDut], a_fall [NDut], a_vld [NDut], a_lock [NDut], a_err [NDut];
   logic [7:0] a_hl [NDut], a_ll [NDut];
   logic [8:0] a_per [NDut];

   assign a_rise[0] = rise0; assign a_fall[0] = fall0; assign a_vld[0] = vld0;
   assign a_rise[1] = rise1; assign a_fall[1] = fall1; assign a_vld[1] = vld1;
   assign a_rise[2] = rise2; assign a_fall[2] = fall2; assign a_vld[2] = vld2;
   assign a_lock[0] = lock0; assign a_err[0]  = err0;
   assign a_lock[1] = lock1; assign a_err[1]  = err1;
   assign a_lock[2] = lock2; assign a_err[2]  = err2;
   assign a_hl[0] = hl0; assign a_ll[0] = ll0; assign a_per[0] = per0;
   assign a_hl[1] = hl1; assign a_ll[1] = ll1; assign a_per[1] = per1;
   assign a_hl[2] = {4'b0, hl2}; assign a_ll[2] = {4'b0, ll2}; assign a_per[2] = {4'b0, per2};

   // Model: edges are the driven waveform seen three samples late; lengths are the
   // distances between consecutive edge pulses; a phase reaching MaxLen is a timeout.
   int cyc = 0;
   bit h1, h2, h3;
   int arm [NDut];
   bit in_hi [NDut];
   int t0 [NDut], good [NDut];
   bit e_rise [NDut], e_fall [NDut], e_vld [NDut], e_err [NDut], e_lock [NDut];
   int e_hl [NDut], e_ll [NDut], e_per [NDut];

   function automatic bit phase_ok(input int len, input int tol);
      return (len >= Half - tol) && (len <= Half + tol);
   endfunction

   always @(posedge clk) begin
      bit r, f;
      int len;
      r = h2 & ~h3;
      f = ~h2 & h3;
      for (int i = 0; i < NDut; i++) begin
         e_rise[i] = 0; e_fall[i] = 0; e_vld[i] = 0; e_err[i] = 0;
         len = cyc - t0[i];
         if (!rst_n) begin
            e_hl[i] = 0; e_ll[i] = 0; e_per[i] = 0; e_lock[i] = 0; good[i] = 0; arm[i] = 0;
         end else if (!en) begin
            e_lock[i] = 0; good[i] = 0; arm[i] = 0;
         end else begin
            e_rise[i] = r;
            e_fall[i] = f;
            if (arm[i] == 0) begin
               arm[i] = 1;
            end else if (arm[i] == 1) begin
               if (r) begin arm[i] = 2; in_hi[i] = 1; t0[i] = cyc; end
            end else if (in_hi[i] && f) begin
               e_hl[i] = len; in_hi[i] = 0; t0[i] = cyc;
            end else if (!in_hi[i] && r) begin
               e_ll[i] = len; e_per[i] = e_hl[i] + len; e_vld[i] = 1;
               in_hi[i] = 1; t0[i] = cyc;
               if (phase_ok(e_hl[i], TolV[i]) && phase_ok(len, TolV[i])) begin
                  if (good[i] < LockN) good[i]++;
                  e_lock[i] = (good[i] == LockN);
               end else begin
                  e_err[i] = 1; good[i] = 0; e_lock[i] = 0;
               end
            end else if (len >= MaxLen[i]) begin
               e_err[i] = 1; good[i] = 0; e_lock[i] = 0; arm[i] = 1;
            end
         end
      end
      if (!rst_n) begin
         h1 = 0; h2 = 0; h3 = 0;
      end else begin
         h3 = h2; h2 = h1; h1 = div_clk;
      end
      cyc++;
   end

   int n_chk = 0;
   int n_fail = 0;
   int errcnt [NDut];
   int rel_cyc = 32'h7fffffff;
   bit first_seen = 0;
   int first_hl, first_ll, first_per;

   task automatic compare_all();
      logic [29:0] exp_v, act_v;
      for (int i = 0; i < NDut; i++) begin
         exp_v = {e_rise[i], e_fall[i], e_vld[i], e_err[i], e_lock[i],
                  8'(e_hl[i]), 8'(e_ll[i]), 9'(e_per[i])};
         act_v = {a_rise[i], a_fall[i], a_vld[i], a_err[i], a_lock[i],
                  a_hl[i], a_ll[i], a_per[i]};
         n_chk++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL model_cmp dut%0d cyc %0d: got {r,f,v,e,l,hi,lo,per}=%h need %h",
                     i, cyc, act_v, exp_v);
         end
         if (a_err[i] === 1'b1) errcnt[i]++;
      end
      if (!first_seen && a_vld[0] === 1'b1 && cyc > rel_cyc) begin
         first_seen = 1;
         first_hl   = int'(a_hl[0]);
         first_ll   = int'(a_ll[0]);
         first_per  = int'(a_per[0]);
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, need %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input int hi, input int lo);
      for (int k = 0; k < hi; k++) begin tick(); div_clk = 1'b1; end
      for (int k = 0; k < lo; k++) begin tick(); div_clk = 1'b0; end
   endtask

   initial begin
      tick(); tick(); tick();
      check("reset_locked", int'(lock0), 0);
      check("reset_period", int'(per0), 0);
      check("reset_high", int'(hl0), 0);
      rst_n = 1'b1;
      en    = 1'b1;

      // Ideal divide-by-8.
      repeat (8) drive(4, 4);
      check("ideal_high", int'(hl0), 4);
      check("ideal_low", int'(ll0), 4);
      check("ideal_period", int'(per0), 8);
      check("ideal_locked", int'(lock0), 1);
      check("ideal_period_w4", int'(per2), 8);
      check("ideal_locked_tol1", int'(lock1), 1);
      check("ideal_no_err", errcnt[0], 0);

      // One 5-high period.
      drive(5, 4);
      repeat (6) drive(4, 4);
      check("glitch_err_tol0", errcnt[0], 1);
      check("glitch_err_tol1", errcnt[1], 0);
      check("glitch_err_w4", errcnt[2], 1);
      check("glitch_relock", int'(lock0), 1);
      check("glitch_lock_tol1", int'(lock1), 1);

      // Stuck high for 20 cycles: timeout only for CNT_W=4.
      drive(20, 4);
      repeat (6) drive(4, 4);
      check("stuck_err_w4", errcnt[2], 2);
      check("stuck_err_tol0", errcnt[0], 2);
      check("stuck_err_tol1", errcnt[1], 1);
      check("stuck_relock_w4", int'(lock2), 1);
      check("stuck_high_w4", int'(hl2), 4);

      // Reset in the middle of a high phase.
      drive(4, 0);
      tick();
      rst_n = 1'b0;
      tick();
      check("midrst_locked", int'(lock0), 0);
      check("midrst_period", int'(per0), 0);
      check("midrst_high", int'(hl0), 0);
      check("midrst_low", int'(ll0), 0);
      div_clk = 1'b0;
      tick(); tick();
      rel_cyc = cyc;
      rst_n   = 1'b1;
      tick(); tick();
      repeat (6) drive(4, 4);
      check("postrst_seen", int'(first_seen), 1);
      check("postrst_high", first_hl, 4);
      check("postrst_low", first_ll, 4);
      check("postrst_period", first_per, 8);
      check("postrst_locked", int'(lock0), 1);

      // Disable for 10 cycles while the input keeps toggling.
      en = 1'b0;
      drive(4, 4);
      drive(2, 0);
      check("dis_locked", int'(lock0), 0);
      check("dis_high_hold", int'(hl0), 4);
      check("dis_period_hold", int'(per0), 8);
      check("dis_no_err", errcnt[0], 2);
      en = 1'b1;
      drive(2, 4);
      repeat (6) drive(4, 4);
      check("reen_locked", int'(lock0), 1);
      check("reen_locked_tol1", int'(lock1), 1);
      check("reen_locked_w4", int'(lock2), 1);
      check("reen_no_err", errcnt[0], 2);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
